// File: rtl/sd_cmd_arbiter.sv
// Arbitrates the SD command engine between the init sequencer (req0) and the
// block read/write controller (req1), one command at a time with an idle gap.
module sd_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13,
    parameter int GAP_CYCLES     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic [2:0]  i_sel0,
    input  logic [31:0] i_arg0,
    output logic        o_done0,
    input  logic        i_req1,
    input  logic [2:0]  i_sel1,
    input  logic [31:0] i_arg1,
    output logic        o_done1,
    output logic [7:0]  o_status,
    output logic        o_timeout,
    output logic        o_grant,
    output logic        o_busy,
    output logic        o_send_cmd,
    output logic [2:0]  o_cmd_select,
    output logic [31:0] o_cmd_arg,
    input  logic        i_confirm_pin,
    input  logic [7:0]  i_response_status
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LD     = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [GAP_W-1:0]   gap_q,     gap_d;
    logic               last_q,    last_d;
    logic               grant_q,   grant_d;
    logic [2:0]         sel_q,     sel_d;
    logic [31:0]        arg_q,     arg_d;
    logic               send_q,    send_d;
    logic               done0_q,   done0_d;
    logic               done1_q,   done1_d;
    logic [7:0]         status_q,  status_d;
    logic               timeout_q, timeout_d;
    logic               busy_q,    busy_d;
    logic               pick_s;

    // With both requesting, the one not served last wins; last_q resets to 1 so req0 goes first.
    assign pick_s = (i_req0 && i_req1) ? ~last_q : ~i_req0;

    // Next-state and output computation; outputs change on the edge entering each state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        last_d    = last_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        arg_d     = arg_q;
        status_d  = status_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        send_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req0 || i_req1) begin
                    grant_d = pick_s;
                    sel_d   = pick_s ? i_sel1 : i_sel0;
                    arg_d   = pick_s ? i_arg1 : i_arg0;
                    send_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                cnt_d   = TIMEOUT_LD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A confirm on the expiry cycle takes priority over the timeout.
                if (i_confirm_pin) begin
                    status_d  = i_response_status;
                    timeout_d = 1'b0;
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    state_d   = ST_DONE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d     = '0;
                    status_d  = 8'hFF;
                    timeout_d = 1'b1;
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_d = grant_q;
                if (GAP_CYCLES == 0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = GAP_LD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q - GAP_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            sel_q     <= 3'd0;
            arg_q     <= 32'd0;
            send_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            status_q  <= 8'd0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            arg_q     <= arg_d;
            send_q    <= send_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign o_done0      = done0_q;
    assign o_done1      = done1_q;
    assign o_status     = status_q;
    assign o_timeout    = timeout_q;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;
    assign o_send_cmd   = send_q;
    assign o_cmd_select = sel_q;
    assign o_cmd_arg    = arg_q;

endmodule
